// File: rtl/tt_lut_eval_if.sv
// tt_lut_eval_if: evaluation handshake and serial table-load bus for tt_lut_eval
interface tt_lut_eval_if #(
  parameter int N_IN = 3
);
  logic [N_IN-1:0] in;
  logic in_valid;
  logic in_ready;
  logic out;
  logic out_valid;
  logic cfg_start;
  logic cfg_bit;
  logic cfg_bit_valid;
  logic cfg_busy;
  modport master (
    output in, in_valid, cfg_start, cfg_bit, cfg_bit_valid,
    input  in_ready, out, out_valid, cfg_busy
  );
  modport slave (
    input  in, in_valid, cfg_start, cfg_bit, cfg_bit_valid,
    output in_ready, out, out_valid, cfg_busy
  );
endinterface

// File: rtl/tt_lut_eval.sv
// tt_lut_eval: truth-table lookup with serial table reload; define TT_PERSIST_FILTER_EN for the output persistence filter
module tt_lut_eval #(
  parameter int N_IN = 3,
  parameter logic [(1<<N_IN)-1:0] TT_RESET = 'hDC,
  parameter int PERSIST = 4
) (
  input logic clk,
  input logic rst_n,
  tt_lut_eval_if.slave lut
);
  localparam int W = 1 << N_IN;
  localparam int CW = $clog2(W) + 1;
  typedef enum logic {RUN, LOAD} state_t;
  if (N_IN < 1 || N_IN > 6 || PERSIST < 2 || PERSIST > 15) begin : g_bad_param
    $error("tt_lut_eval: parameter out of range");
  end
  state_t state_q;
  logic [W-1:0] tbl_q, shd_q, shd_d;
  logic [CW-1:0] cnt_q;
  logic [N_IN-1:0] idx;
  logic rs_q, rdy_q, busy_q, out_q, ov_q, res_d, out_d, acc, done;
  // table bit W-1-k holds entry k, and W-1-k is simply ~k in N_IN bits
  assign idx = ~lut.in;
  assign res_d = tbl_q[idx];
  // first bit shifted in ends up in the MSB (entry 0) after W shifts
  assign shd_d = {shd_q[W-2:0], lut.cfg_bit};
  // ready is held low from reset release until the synchroniser has seen one edge
  assign lut.in_ready = rdy_q && (rs_q || !rst_n);
  assign acc = lut.in_valid && lut.in_ready && !lut.cfg_start;
  assign done = state_q == LOAD && lut.cfg_bit_valid && !lut.cfg_start && cnt_q == CW'(W - 1);
  assign lut.out = out_q;
  assign lut.out_valid = ov_q;
  assign lut.cfg_busy = busy_q;
`ifdef TT_PERSIST_FILTER_EN
  logic [3:0] fc_q, fc_d;
  // out only moves once PERSIST consecutive results disagree with it
  always_comb begin
    out_d = (res_d != out_q && fc_q == 4'(PERSIST - 1)) ? res_d : out_q;
    fc_d = (res_d == out_q || fc_q == 4'(PERSIST - 1)) ? 4'd0 : fc_q + 4'd1;
  end
  // filter counter: advances per evaluation, restarts on a fresh table
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fc_q <= '0;
    else if (acc) fc_q <= fc_d;
    else if (done) fc_q <= '0;
`else
  assign out_d = res_d;
`endif
  // RUN/LOAD control, table shadowing and registered evaluation output
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      tbl_q <= TT_RESET;
      shd_q <= '0;
      cnt_q <= '0;
      rs_q <= 1'b0;
      rdy_q <= 1'b1;
      busy_q <= 1'b0;
      out_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      rs_q <= 1'b1;
      ov_q <= acc;
      if (acc) out_q <= out_d;
      if (rs_q && lut.cfg_start) begin
        state_q <= LOAD;
        rdy_q <= 1'b0;
        busy_q <= 1'b1;
        cnt_q <= '0;
        shd_q <= '0;
      end else if (state_q == LOAD && lut.cfg_bit_valid) begin
        shd_q <= shd_d;
        cnt_q <= cnt_q + 1'b1;
        if (done) begin
          tbl_q <= shd_d;
          state_q <= RUN;
          rdy_q <= 1'b1;
          busy_q <= 1'b0;
        end
      end
    end
endmodule

// File: doc/tt_lut_eval.md
TT_LUT_EVAL -- requirements
Module: tt_lut_eval

Interface
REQ-001 Parameter N_IN, default 3: number of logic inputs, legal range 1..6.
REQ-002 Parameter TT_RESET, default 8'hDC (width 2^N_IN): truth table loaded at reset.
REQ-003 Parameter PERSIST, default 4: consecutive-agreement count for the persistence filter, legal range 2..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in  input  N_IN  logic inputs; in[N_IN-1] is in1 (MSB), in[0] is the last input.
REQ-007 in_valid  input  1  in is presented for evaluation.
REQ-008 in_ready  output  1  block accepts an evaluation this cycle.
REQ-009 out  output  1  registered logic output.
REQ-010 out_valid  output  1  single-cycle pulse marking a completed evaluation.
REQ-011 cfg_start  input  1  begin a serial truth-table load.
REQ-012 cfg_bit  input  1  serial truth-table data.
REQ-013 cfg_bit_valid  input  1  cfg_bit is valid this cycle.
REQ-014 cfg_busy  output  1  load in progress.

Function
REQ-015 Table encoding: the table is 2^N_IN bits; entry for input index k (the value of in) is table bit [2^N_IN-1-k], so 8'hDC gives 000->1, 001->1, 010->0, 011->1, 100->1, 101->1, 110->0, 111->0.
REQ-016 FSM has two states, RUN and LOAD; reset state is RUN.
REQ-017 RUN: in_ready=1, cfg_busy=0; an accept (in_valid && in_ready) evaluates the active table at in.
REQ-018 Latency: evaluation result appears on out, and out_valid pulses high, exactly one cycle after the accept; out holds its value between evaluations.
REQ-019 Back-to-back accepts on consecutive cycles produce consecutive out_valid pulses with no bubbles.
REQ-020 RUN -> LOAD on cfg_start=1; cfg_start takes priority over an in_valid in the same cycle, and that input is not accepted.
REQ-021 LOAD: in_ready=0, cfg_busy=1; each cycle with cfg_bit_valid=1 shifts cfg_bit into a shadow register, with the first bit being the entry for index 0 (table MSB).
REQ-022 A bit counter of width clog2(2^N_IN)+1 counts accepted bits; when bit 2^N_IN is accepted, the shadow is copied to the active table and the FSM returns to RUN on the next edge.
REQ-023 The new table is used from the first accept after the return to RUN; a partially loaded shadow never affects out.
REQ-024 cfg_start asserted while in LOAD restarts the load: counter cleared, partial shadow discarded, FSM remains in LOAD.
REQ-025 cfg_bit_valid in RUN is ignored.
REQ-026 out_valid never asserts in LOAD except for the pulse belonging to an accept in the last RUN cycle.

Reset
REQ-027 While rst_n=0: state=RUN, active table=TT_RESET, shadow=0, counter=0, out=0, out_valid=0, in_ready=1, cfg_busy=0, filter counter=0.
REQ-028 Reset asserted in LOAD aborts the load; the active table reverts to TT_RESET.
REQ-029 Reset deassertion is synchronised into the FSM so the first accept occurs no earlier than the second rising edge after rst_n rises.

Configuration
REQ-030 The macro TT_PERSIST_FILTER_EN compiles in a persistence filter.
REQ-031 When the macro is defined, out changes only after PERSIST consecutive evaluations yield the same value differing from the current out; any evaluation equal to out clears the filter counter.
REQ-032 When the macro is defined, out_valid still pulses on every evaluation, and completing a table load clears the filter counter.
REQ-033 When the macro is undefined, no filter logic exists and out takes every evaluation result directly.

Verification
REQ-034 Reset, then apply in=010 and 011 on consecutive accepts -> out_valid on 2 consecutive cycles, with out=0 then 1.
REQ-035 Sweep in=000..111 with default table -> out sequence 1,1,0,1,1,1,0,0.
REQ-036 Pulse cfg_start, then shift 8 bits for 8'h01 with gaps in cfg_bit_valid -> in_ready=0 throughout; afterwards in=111 -> 1 and in=000 -> 0.
REQ-037 Abort a load: cfg_start, 3 bits, cfg_start, 8 bits of 8'hFF -> all entries read 1; a second case with rst_n pulsed mid-load -> the table reads 8'hDC.
REQ-038 Simultaneous cfg_start and in_valid -> no out_valid pulse, and cfg_busy=1 the next cycle.
REQ-039 With TT_PERSIST_FILTER_EN and PERSIST=4, out=1: apply three 0-results, one 1-result, then four 0-results -> out stays 1 until the fourth consecutive 0, then becomes 0.
